// File: rtl/serial_add_sequencer_pkg.sv
// Shared definitions for the serial adder sequencer and its bench.
package serial_add_sequencer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_collect_reg.sv
// Right-shift collector: each enabled edge inserts d at the MSB, so the first bit ends at bit 0.
module serial_collect_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= {d, q[WIDTH-1:1]};
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// Feeds a parallel operand LSB-first into a serial adder and collects the serial sum
// into a parallel result, with valid/ready handshakes on both sides.
module serial_add_sequencer
    import serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operand,
    output logic             ser_bit,
    output logic             shift_en,
    output logic             adder_clear_n,
    input  logic             sum_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] counter_inc;
    logic [WIDTH-1:0] operand;

    assign counter_inc = counter + CNT_W'(1);

    // Outputs are registered together with the state they belong to, so each one
    // always reflects the current state and never depends on in_valid/out_ready.
    // NOTE: every register here uses <= so all of them see pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            counter       <= '0;
            operand       <= '0;
            in_ready      <= 1'b1;
            shift_en      <= 1'b0;
            adder_clear_n <= 1'b1;
            ser_bit       <= 1'b0;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        operand       <= in_operand;
                        counter       <= '0;
                        state         <= ST_CLEAR;
                        in_ready      <= 1'b0;
                        adder_clear_n <= 1'b0;
                        busy          <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state         <= ST_SHIFT;
                    adder_clear_n <= 1'b1;
                    shift_en      <= 1'b1;
                    ser_bit       <= operand[0];
                end
                ST_SHIFT: begin
                    if (counter == LAST) begin
                        counter   <= '0;
                        state     <= ST_DONE;
                        shift_en  <= 1'b0;
                        ser_bit   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        counter <= counter_inc;
                        ser_bit <= operand[counter_inc];
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // shift_en is high exactly in SHIFT, so it doubles as the sample enable for sum_bit.
    serial_collect_reg #(.WIDTH(WIDTH)) u_collect (
        .clock (clock),
        .reset (reset),
        .en    (shift_en),
        .d     (sum_bit),
        .q     (out_result)
    );

endmodule
